// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: func3 encodings, FSM states, special results.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply over {hi,lo}, or restoring divide with hi=rem, lo=quot.
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_op,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opa,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opa};
    if (div_op) begin
      // Remainder never exceeds the divisor, so the shifted value fits XLEN+1 bits.
      if (shifted >= {1'b0, opa}) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Define MULDIV_FAST_MUL_EN to compute MUL* ops in a single cycle; divides always iterate.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [2:0]       func3_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  hi_q, lo_q, opa_q;
  logic             neg_q_q, neg_r_q;

  logic            div_op, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN-1:0] hi_next, lo_next, final_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Handshake: start_i is the valid from ID/EX; the instruction is taken in the IDLE cycle where
  // start_i & ~flush, and stall_o holds ID/EX stable until the done_o cycle, in which it is low.
  assign stall_o = ~flush & (((state == ST_IDLE) & start_i) | (state == ST_BUSY));
  assign busy_o  = (state != ST_IDLE);

  always_comb begin
    div_op = func3_i[2];
    if (div_op) begin
      a_sgn = ~func3_i[0];
      b_sgn = ~func3_i[0];
    end else begin
      a_sgn = (func3_i != F3_MULHU);
      b_sgn = (func3_i == F3_MUL) || (func3_i == F3_MULH);
    end
    a_neg    = a_sgn & rs1_data_i[XLEN-1];
    b_neg    = b_sgn & rs2_data_i[XLEN-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    div_zero = div_op & (rs2_data_i == '0);
    div_ovf  = div_op & ~func3_i[0] & (rs1_data_i == INT_MIN) & (rs2_data_i == '1);
    if (div_zero) special_res = func3_i[1] ? rs1_data_i : DIV0_QUOT;
    else          special_res = func3_i[1] ? '0 : INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;
  logic [XLEN-1:0]          fast_res;
  always_comb begin
    fast_a    = {a_sgn & rs1_data_i[XLEN-1], rs1_data_i};
    fast_b    = {b_sgn & rs2_data_i[XLEN-1], rs2_data_i};
    fast_prod = fast_a * fast_b;
    fast_res  = (func3_i == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .div_op  (func3_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .opa     (opa_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Sign correction applied to the values the final iteration produces.
  always_comb begin
    prod     = {hi_next, lo_next};
    prod_fix = neg_q_q ? -prod : prod;
    case (func3_q)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = neg_q_q ? -lo_next : lo_next;
      default:                      final_res = neg_r_q ? -hi_next : hi_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      func3_q  <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opa_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !flush) begin
            func3_q <= func3_i;
            rd_q    <= rd_i;
            if (div_zero || div_ovf) begin
              result_o <= special_res;
              rd_o     <= rd_i;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!div_op) begin
              result_o <= fast_res;
              rd_o     <= rd_i;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end
`endif
            else begin
              // Divide: lo holds the dividend shifting into the quotient; multiply: lo holds the multiplier.
              hi_q    <= '0;
              lo_q    <= div_op ? a_mag : b_mag;
              opa_q   <= div_op ? b_mag : a_mag;
              neg_q_q <= a_neg ^ b_neg;
              neg_r_q <= a_neg;
              count   <= '0;
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            count <= count + 1'b1;
            if (count == CNT_W'(XLEN-1)) begin
              result_o <= final_res;
              rd_o     <= rd_q;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
